// File: rtl/mac_array_seq_if.sv
// Job-control and FIFO handshake bundle between the MAC array sequencer
// and its surrounding FIFOs / host.
interface mac_array_seq_if #(
  parameter int len_bw = 8
);
  logic              start;
  logic              sel_mode;
  logic [len_bw-1:0] k_len;
  logic              l0_empty;
  logic              w_empty;
  logic              ofifo_afull;
  logic [1:0]        inst_w;
  logic              l0_rd;
  logic              w_rd;
  logic              ofifo_wr;
  logic              busy;
  logic              done;
  logic [15:0]       stall_cnt;

  modport master (
    output start, sel_mode, k_len, l0_empty, w_empty, ofifo_afull,
    input  inst_w, l0_rd, w_rd, ofifo_wr, busy, done, stall_cnt
  );

  modport slave (
    input  start, sel_mode, k_len, l0_empty, w_empty, ofifo_afull,
    output inst_w, l0_rd, w_rd, ofifo_wr, busy, done, stall_cnt
  );
endinterface

// File: rtl/mac_array_seq.sv
// Sequencer for a row x col MAC tile array (weight- or output-stationary jobs).
// Define MAC_ARRAY_SEQ_PERF_CNT_EN to build the saturating stall counter.
module mac_array_seq #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic           clk,
  input  logic           reset,
  mac_array_seq_if.slave bus
);
  localparam int DLY    = row + col - 1;
  localparam int NEED_W = $clog2(row + col) + 1;
  localparam int CNT_W  = (len_bw > NEED_W) ? len_bw : NEED_W;
  localparam logic [CNT_W-1:0] COL_C = CNT_W'(col);
  localparam logic [CNT_W-1:0] ROW_C = CNT_W'(row);
  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(DLY);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KLOAD = 3'd1,
    KGAP  = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    OREAD = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s, klen_ext_s;
  logic [len_bw-1:0]  klen_r, klen_s;
  logic               mode_r, mode_s;
  logic [1:0]         inst_r, inst_s;
  logic               l0_rd_r, l0_rd_s;
  logic               w_rd_r, w_rd_s;
  logic               os_wr_s, ofifo_wr_r;
  logic               busy_r, done_r, done_s;
  logic               stall_s;
  logic [DLY-1:0]     sr_r;

  assign cnt_inc_s  = cnt_r + ONE_C;
  assign klen_ext_s = CNT_W'(klen_r);

  // Next-state and next-output decode; outputs are registered one cycle later.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    klen_s  = klen_r;
    mode_s  = mode_r;
    inst_s  = 2'b00;
    l0_rd_s = 1'b0;
    w_rd_s  = 1'b0;
    os_wr_s = 1'b0;
    done_s  = 1'b0;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          mode_s = bus.sel_mode;
          klen_s = bus.k_len;
          cnt_s  = {CNT_W{1'b0}};
          if (bus.k_len == {len_bw{1'b0}}) begin
            state_s = DONE;
          end else if (bus.sel_mode) begin
            state_s = EXEC;
          end else begin
            state_s = KLOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      KLOAD: begin
        stall_s = bus.l0_empty;
        if (!stall_s) begin
          inst_s  = 2'b01;
          l0_rd_s = 1'b1;
          if (cnt_inc_s == COL_C) begin
            state_s = KGAP;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      KGAP: begin
        state_s = EXEC;
      end
      EXEC: begin
        // OS has no output traffic during EXEC, so only WS waits on ofifo space
        stall_s = bus.l0_empty | (mode_r ? bus.w_empty : bus.ofifo_afull);
        if (!stall_s) begin
          inst_s  = 2'b10;
          l0_rd_s = 1'b1;
          w_rd_s  = mode_r;
          if (cnt_inc_s == klen_ext_s) begin
            state_s = DRAIN;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      DRAIN: begin
        if (cnt_inc_s == DLY_C) begin
          state_s = mode_r ? OREAD : DONE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      OREAD: begin
        stall_s = bus.ofifo_afull;
        if (!stall_s) begin
          os_wr_s = 1'b1;
          if (cnt_inc_s == ROW_C) begin
            state_s = DONE;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, job latches and registered array controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      klen_r     <= {len_bw{1'b0}};
      mode_r     <= 1'b0;
      inst_r     <= 2'b00;
      l0_rd_r    <= 1'b0;
      w_rd_r     <= 1'b0;
      ofifo_wr_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      klen_r     <= klen_s;
      mode_r     <= mode_s;
      inst_r     <= inst_s;
      l0_rd_r    <= l0_rd_s;
      w_rd_r     <= w_rd_s;
      ofifo_wr_r <= sr_r[DLY-1] | os_wr_s;
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
    end
  end

  // WS result timing: issue-valid ripples through the array diagonal, bubbles as 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_r <= {DLY{1'b0}};
    end else begin
      sr_r[0] <= inst_s[1] & ~mode_r;
      for (int i = 1; i < DLY; i++) begin
        sr_r[i] <= sr_r[i-1];
      end
    end
  end

`ifdef MAC_ARRAY_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating stall counter, cleared when a job is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == IDLE) && bus.start) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

  assign bus.inst_w   = inst_r;
  assign bus.l0_rd    = l0_rd_r;
  assign bus.w_rd     = w_rd_r;
  assign bus.ofifo_wr = ofifo_wr_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_mac_array_seq.sv
// Scoreboard bench for mac_array_seq: per-job expectations are queued at start
// and retired on done; WS push times are queued per issue and retired per push.
module tb_mac_array_seq;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LBW = 8;
  localparam int DRN = ROW + COL - 1;

  typedef struct {
    int lat;
    int n01;
    int n10;
    int nwr;
    int nwrd;
  } exp_t;

  logic clk;
  logic reset;
  mac_array_seq_if #(.len_bw(LBW)) bus();

  mac_array_seq #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   wr_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_stall = 0;
  int   m01 = 0, m10 = 0, mwr = 0, mwrd = 0, mbusy = 0;
  logic cur_mode = 1'b0;
  logic done_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {9'd0, bus.inst_w, bus.l0_rd, bus.w_rd, bus.ofifo_wr, bus.busy, bus.done, bus.stall_cnt};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_eq("rst_outs", outs_vec(), 32'd0);
        m01 = 0; m10 = 0; mwr = 0; mwrd = 0; mbusy = 0;
        wr_q.delete();
      end else begin
        if (bus.busy) mbusy++;
        if (bus.inst_w == 2'b01) m01++;
        if (bus.inst_w == 2'b10) begin
          m10++;
          if (!cur_mode) wr_q.push_back(cyc + DRN);
        end
        check_eq("l0_rd_vs_inst", {31'd0, bus.l0_rd}, {31'd0, bus.inst_w != 2'b00});
        check_eq("w_rd_vs_inst", {31'd0, bus.w_rd}, {31'd0, (bus.inst_w == 2'b10) && cur_mode});
        if (bus.w_rd) mwrd++;
        if (bus.ofifo_wr) begin
          mwr++;
          if (!cur_mode) begin
            if (wr_q.size() == 0) check_eq("wr_unexpected", 32'd1, 32'd0);
            else check_eq("wr_time", cyc, wr_q.pop_front());
          end
        end
        if (bus.done) begin
          done_seen = 1'b1;
          if (exp_q.size() == 0) begin
            check_eq("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("latency", cyc - start_cyc, e.lat);
            check_eq("n_kload", m01, e.n01);
            check_eq("n_exec", m10, e.n10);
            check_eq("n_ofifo_wr", mwr, e.nwr);
            check_eq("n_w_rd", mwrd, e.nwrd);
            check_eq("n_busy", mbusy, e.lat);
            check_eq("wr_pending", wr_q.size(), 32'd0);
          end
          m01 = 0; m10 = 0; mwr = 0; mwrd = 0; mbusy = 0;
        end
      end
    end
  end

  // Drive a start pulse and queue what the job must produce (s = stalled cycles).
  task automatic start_job(input logic mode, input int k, input int s);
    exp_t e;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.sel_mode = mode;
    bus.k_len    = k[LBW-1:0];
    cur_mode     = mode;
    start_cyc    = cyc + 1;
    done_seen    = 1'b0;
    last_stall   = s;
    if (k == 0) e.lat = 1;
    else if (mode) e.lat = k + s + DRN + ROW + 1;
    else e.lat = COL + 1 + k + s + DRN + 1;
    e.n01  = (mode || k == 0) ? 0 : COL;
    e.n10  = k;
    e.nwr  = (k == 0) ? 0 : (mode ? ROW : k);
    e.nwrd = mode ? k : 0;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.sel_mode = ~mode;
    bus.k_len    = 8'hA5;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!done_seen && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check_eq("done_seen", {31'd0, done_seen}, 32'd1);
`ifdef MAC_ARRAY_SEQ_PERF_CNT_EN
    check_eq("stall_cnt", bus.stall_cnt, last_stall);
`else
    check_eq("stall_cnt", bus.stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.sel_mode    = 1'b0;
    bus.k_len       = 8'd0;
    bus.l0_empty    = 1'b0;
    bus.w_empty     = 1'b0;
    bus.ofifo_afull = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_state", outs_vec(), 32'd0);
    reset = 1'b1;

    // WS, FIFOs always ready
    start_job(1'b0, 4, 0);
    wait_done();

    // WS, one empty cycle in KLOAD and one afull cycle in EXEC
    start_job(1'b0, 4, 2);
    bus.l0_empty = 1'b1;
    @(negedge clk);
    bus.l0_empty = 1'b0;
    repeat (10) @(negedge clk);
    bus.ofifo_afull = 1'b1;
    @(negedge clk);
    bus.ofifo_afull = 1'b0;
    wait_done();

    // OS, afull must not stall EXEC, w_empty for two cycles does
    start_job(1'b1, 3, 2);
    bus.ofifo_afull = 1'b1;
    @(negedge clk);
    bus.ofifo_afull = 1'b0;
    bus.w_empty     = 1'b1;
    repeat (2) @(negedge clk);
    bus.w_empty = 1'b0;
    wait_done();

    // OS, one afull cycle in OREAD holds the push
    start_job(1'b1, 2, 1);
    repeat (18) @(negedge clk);
    bus.ofifo_afull = 1'b1;
    @(negedge clk);
    bus.ofifo_afull = 1'b0;
    wait_done();

    // Zero-length job
    start_job(1'b0, 0, 0);
    wait_done();

    // Maximum length, no wrap
    start_job(1'b0, 255, 0);
    wait_done();

    // start during DRAIN is ignored; next start latches the new mode
    start_job(1'b0, 2, 0);
    repeat (13) @(negedge clk);
    check_eq("busy_in_drain", {31'd0, bus.busy}, 32'd1);
    bus.start    = 1'b1;
    bus.sel_mode = 1'b1;
    bus.k_len    = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check_eq("start_ignored", {31'd0, bus.busy}, 32'd0);
    start_job(1'b1, 1, 0);
    wait_done();

    // Reset mid-EXEC aborts; a following job runs normally
    start_job(1'b0, 8, 0);
    repeat (12) @(negedge clk);
    check_eq("pre_reset_exec", {30'd0, bus.inst_w}, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_reset", outs_vec(), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_job(1'b0, 3, 0);
    wait_done();

    repeat (3) @(negedge clk);
    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
